// File: rtl/clock_period_meter_if.sv
// Bundles the measurement control input, the signal under test and the
// measurement results shared between the meter and whoever consumes them.
interface clock_period_meter_if #(
    parameter int W = 16,
    parameter int N = 3
);
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic [N-1:0] prescale_code;
    logic         code_exact;
    logic         locked;
    logic         timeout;

    // Side that enables the meter, supplies the signal and reads results.
    modport master (
        output en,
        output sig_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  prescale_code,
        input  code_exact,
        input  locked,
        input  timeout
    );

    // The meter itself.
    modport slave (
        input  en,
        input  sig_in,
        output period,
        output high_time,
        output period_valid,
        output prescale_code,
        output code_exact,
        output locked,
        output timeout
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow signal in clk_in cycles and
// reports the power-of-two prescale code that reproduces the period.
module clock_period_meter #(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic                clk_in,
    input  logic                rst_n,
    clock_period_meter_if.slave bus
);
    localparam logic [1:0]   IDLE     = 2'd0;
    localparam logic [1:0]   ARM      = 2'd1;
    localparam logic [1:0]   MEASURE  = 2'd2;
    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam int           CODE_MAX = (1 << N) - 1;

    logic         sync1_reg;
    logic         sync2_reg;
    logic         dly_reg;
    logic         rise;
    logic         fall;

    logic [1:0]   state_reg;
    logic [W-1:0] counter_reg;
    logic [W-1:0] hi_hold_reg;
    logic [W-1:0] period_reg;
    logic [W-1:0] high_time_reg;
    logic         period_valid_reg;
    logic [N-1:0] code_reg;
    logic         exact_reg;
    logic         locked_reg;
    logic         timeout_reg;
    logic         have_prev_reg;

    int           msb_idx;
    int           code_clamped;
    logic [N-1:0] code_next;
    logic         one_hot;
    logic         exact_next;

    // Two-flop synchronizer followed by a delay flop for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            dly_reg   <= 1'b0;
        end else begin
            sync1_reg <= bus.sig_in;
            sync2_reg <= sync1_reg;
            dly_reg   <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~dly_reg;
    assign fall = ~sync2_reg & dly_reg;

    // Prescale code and exactness of the count about to be captured.
    always_comb begin
        msb_idx = 0;
        for (int i = 0; i < W; i++) begin
            if (counter_reg[i]) begin
                msb_idx = i;
            end
        end
        code_clamped = (msb_idx > CODE_MAX) ? CODE_MAX : msb_idx;
        code_next    = N'(code_clamped);
        one_hot      = (counter_reg != '0) &&
                       ((counter_reg & (counter_reg - 1'b1)) == '0);
        exact_next   = one_hot && (msb_idx <= CODE_MAX);
    end

    // Measurement FSM: arm on the first rising edge, then capture a period
    // on every following rising edge; give up and re-arm on saturation.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            counter_reg      <= '0;
            hi_hold_reg      <= '0;
            period_reg       <= '0;
            high_time_reg    <= '0;
            period_valid_reg <= 1'b0;
            code_reg         <= '0;
            exact_reg        <= 1'b0;
            locked_reg       <= 1'b0;
            timeout_reg      <= 1'b0;
            have_prev_reg    <= 1'b0;
        end else begin
            period_valid_reg <= 1'b0;
            if (!bus.en) begin
                state_reg     <= IDLE;
                counter_reg   <= '0;
                locked_reg    <= 1'b0;
                timeout_reg   <= 1'b0;
                have_prev_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        counter_reg <= '0;
                        state_reg   <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            counter_reg <= {{(W-1){1'b0}}, 1'b1};
                            state_reg   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (fall) begin
                            hi_hold_reg <= counter_reg;
                        end
                        // A rising edge takes priority over saturation.
                        if (rise) begin
                            period_reg       <= counter_reg;
                            high_time_reg    <= hi_hold_reg;
                            code_reg         <= code_next;
                            exact_reg        <= exact_next;
                            period_valid_reg <= 1'b1;
                            locked_reg       <= have_prev_reg && (counter_reg == period_reg);
                            have_prev_reg    <= 1'b1;
                            timeout_reg      <= 1'b0;
                            counter_reg      <= {{(W-1){1'b0}}, 1'b1};
                        end else if (counter_reg == CNT_MAX) begin
                            timeout_reg   <= 1'b1;
                            locked_reg    <= 1'b0;
                            have_prev_reg <= 1'b0;
                            counter_reg   <= '0;
                            state_reg     <= ARM;
                        end else begin
                            counter_reg <= counter_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        counter_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.period        = period_reg;
    assign bus.high_time     = high_time_reg;
    assign bus.period_valid  = period_valid_reg;
    assign bus.prescale_code = code_reg;
    assign bus.code_exact    = exact_reg;
    assign bus.locked        = locked_reg;
    assign bus.timeout       = timeout_reg;
endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter: a W=16/N=3 instance checked by a
// table of waveforms plus random waveforms against a time-based model, and
// a W=8/N=1 instance exercising timeout and code clamping by hand.
module tb_clock_period_meter;
    localparam int MW = 16;
    localparam int MN = 3;
    localparam int SW = 8;
    localparam int SN = 1;
    localparam int M_CODE_MAX = (1 << MN) - 1;
    localparam int NROWS = 9;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int period;
        int high;
        int code;
        int exact;
    } row_t;

    typedef struct {
        int period;
        int high;
        int code;
        int exact;
        int locked;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_period_meter_if #(.W(MW), .N(MN)) m_if ();
    clock_period_meter_if #(.W(SW), .N(SN)) s_if ();

    clock_period_meter #(.W(MW), .N(MN)) dut_m (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (m_if.slave)
    );

    clock_period_meter #(.W(SW), .N(SN)) dut_s (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (s_if.slave)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    row_t rows[NROWS];
    row_t dummy;

    // Model state: times of sig_in edges as driven, and lock history.
    int   have_rise = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    int   have_prev = 0;
    int   prev_p = 0;
    int   pend_tab = 0;
    row_t pend_row;

    // Latest valid capture of the small instance.
    int s_vcount = 0;
    int s_period = 0;
    int s_high = 0;
    int s_code = 0;
    int s_exact = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic int flog2(input int p);
        int l = 0;
        while ((p >> (l + 1)) != 0) l++;
        return l;
    endfunction

    function automatic int ref_code(input int p);
        int l = flog2(p);
        return (l > M_CODE_MAX) ? M_CODE_MAX : l;
    endfunction

    function automatic int ref_exact(input int p);
        int l = flog2(p);
        return (((1 << l) == p) && (l <= M_CODE_MAX)) ? 1 : 0;
    endfunction

    // Drive a rising edge; the period it closes becomes an expected valid.
    task automatic do_rise(input int tab, input row_t r);
        exp_t e;
        int p;
        int h;
        if (have_rise != 0) begin
            p = cyc - last_rise;
            h = last_fall - last_rise;
            if (pend_tab != 0) begin
                e.period = pend_row.period;
                e.high   = pend_row.high;
                e.code   = pend_row.code;
                e.exact  = pend_row.exact;
            end else begin
                e.period = p;
                e.high   = h;
                e.code   = ref_code(p);
                e.exact  = ref_exact(p);
            end
            e.locked  = ((have_prev != 0) && (e.period == prev_p)) ? 1 : 0;
            prev_p    = e.period;
            have_prev = 1;
            q.push_back(e);
        end
        have_rise = 1;
        last_rise = cyc;
        pend_tab  = tab;
        pend_row  = r;
        m_if.sig_in = 1'b1;
    endtask

    task automatic do_fall();
        last_fall = cyc;
        m_if.sig_in = 1'b0;
    endtask

    task automatic wave(input int hi, input int lo);
        do_rise(0, dummy);
        tick(hi);
        do_fall();
        tick(lo);
    endtask

    // Scoreboard for the main instance.
    always @(negedge clk) begin
        if (rst_n && m_if.period_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with period %0d, expected no valid (cycle %0d)",
                         m_if.period, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("period", int'(m_if.period), mon_e.period);
                chk("high_time", int'(m_if.high_time), mon_e.high);
                chk("prescale_code", int'(m_if.prescale_code), mon_e.code);
                chk("code_exact", int'(m_if.code_exact), mon_e.exact);
                chk("locked", int'(m_if.locked), mon_e.locked);
                chk("timeout_at_valid", int'(m_if.timeout), 0);
            end
        end
    end

    // Capture of the small instance's results.
    always @(negedge clk) begin
        if (rst_n && s_if.period_valid) begin
            s_vcount <= s_vcount + 1;
            s_period <= int'(s_if.period);
            s_high   <= int'(s_if.high_time);
            s_code   <= int'(s_if.prescale_code);
            s_exact  <= int'(s_if.code_exact);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int hi;
        int lo;
        int reps;

        dummy = '{default: 0};
        rows[0] = '{4,   4,   3, 8,   4,   3, 1};
        rows[1] = '{5,   7,   3, 12,  5,   3, 0};
        rows[2] = '{6,   6,   2, 12,  6,   3, 0};
        rows[3] = '{5,   5,   2, 10,  5,   3, 0};
        rows[4] = '{1,   1,   3, 2,   1,   1, 1};
        rows[5] = '{100, 28,  2, 128, 100, 7, 1};
        rows[6] = '{150, 150, 2, 300, 150, 7, 0};
        rows[7] = '{128, 128, 1, 256, 128, 7, 0};
        rows[8] = '{2,   1,   2, 3,   2,   1, 0};

        m_if.en = 1'b0;
        m_if.sig_in = 1'b0;
        s_if.en = 1'b0;
        s_if.sig_in = 1'b0;
        rst_n = 1'b0;
        tick(3);

        chk("rst_period", int'(m_if.period), 0);
        chk("rst_high_time", int'(m_if.high_time), 0);
        chk("rst_valid", int'(m_if.period_valid), 0);
        chk("rst_code", int'(m_if.prescale_code), 0);
        chk("rst_exact", int'(m_if.code_exact), 0);
        chk("rst_locked", int'(m_if.locked), 0);
        chk("rst_timeout", int'(m_if.timeout), 0);
        rst_n = 1'b1;
        tick(2);

        // Small instance: lock, saturate, recover, clamp the code.
        s_if.en = 1'b1;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            s_if.sig_in = 1'b1;
            tick(4);
            s_if.sig_in = 1'b0;
            if (i < 3) tick(4);
        end
        chk("s_locked_before_timeout", int'(s_if.locked), 1);
        n = 4;
        while (n < 400 && !s_if.timeout) begin
            tick(1);
            n++;
        end
        chk("s_timeout_cycles", n, 258);
        chk("s_timeout", int'(s_if.timeout), 1);
        chk("s_locked_after_timeout", int'(s_if.locked), 0);
        chk("s_period_held", int'(s_if.period), 8);
        chk("s_code_held", int'(s_if.prescale_code), 1);
        chk("s_valid_count_a", s_vcount, 3);
        tick(5);
        s_if.sig_in = 1'b1;
        tick(5);
        s_if.sig_in = 1'b0;
        tick(5);
        s_if.sig_in = 1'b1;
        tick(5);
        chk("s_valid_count_b", s_vcount, 4);
        chk("s_period_10", s_period, 10);
        chk("s_high_5", s_high, 5);
        chk("s_timeout_cleared", int'(s_if.timeout), 0);
        chk("s_code_10", s_code, 1);
        chk("s_exact_10", s_exact, 0);
        chk("s_locked_first", int'(s_if.locked), 0);
        s_if.sig_in = 1'b0;
        tick(11);
        s_if.sig_in = 1'b1;
        tick(5);
        chk("s_valid_count_c", s_vcount, 5);
        chk("s_period_16", s_period, 16);
        chk("s_code_16_clamped", s_code, 1);
        chk("s_exact_16", s_exact, 0);
        s_if.sig_in = 1'b0;
        s_if.en = 1'b0;
        tick(2);

        // Main instance: table of waveforms.
        m_if.en = 1'b1;
        tick(4);
        for (int i = 0; i < NROWS; i++) begin
            for (int k = 0; k < rows[i].reps; k++) begin
                do_rise(1, rows[i]);
                tick(rows[i].hi);
                do_fall();
                tick(rows[i].lo);
            end
        end

        // Random waveforms against the model.
        for (int i = 0; i < 25; i++) begin
            hi   = int'($urandom_range(1, 20));
            lo   = int'($urandom_range(1, 20));
            reps = int'($urandom_range(1, 3));
            for (int k = 0; k < reps; k++) wave(hi, lo);
        end
        wave(4, 6);

        // Enable dropped for 3 cycles during a low phase.
        for (int k = 0; k < 3; k++) wave(6, 6);
        do_rise(0, dummy);
        tick(6);
        do_fall();
        tick(4);
        chk("pre_drop_locked", int'(m_if.locked), 1);
        m_if.en = 1'b0;
        have_rise = 0;
        have_prev = 0;
        tick(1);
        chk("drop_locked", int'(m_if.locked), 0);
        chk("drop_period_held", int'(m_if.period), 12);
        chk("drop_timeout", int'(m_if.timeout), 0);
        tick(2);
        m_if.en = 1'b1;
        tick(6);
        wave(6, 6);
        wave(6, 6);
        wave(6, 6);

        // Asynchronous reset in the middle of a measurement.
        wave(5, 5);
        wave(5, 5);
        do_rise(0, dummy);
        tick(5);
        do_fall();
        tick(3);
        chk("pre_reset_locked", int'(m_if.locked), 1);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        have_rise = 0;
        have_prev = 0;
        #1;
        chk("arst_period", int'(m_if.period), 0);
        chk("arst_high_time", int'(m_if.high_time), 0);
        chk("arst_code", int'(m_if.prescale_code), 0);
        chk("arst_exact", int'(m_if.code_exact), 0);
        chk("arst_locked", int'(m_if.locked), 0);
        chk("arst_timeout", int'(m_if.timeout), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        wave(7, 7);
        wave(7, 7);
        wave(7, 7);

        tick(10);
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
